// File: rtl/vdp_cpu_bus_ifce_if.sv
// CPU-side I/O bus of the VDP: asynchronous Z8S180 strobes in, read-data bus and buffer enable out.
interface vdp_cpu_bus_ifce_if;
   logic       cpu_iorq_n;
   logic       cpu_rd_n;
   logic       cpu_wr_n;
   logic       cpu_csel;
   logic       cpu_mode;
   logic [7:0] cpu_din;
   logic [7:0] cpu_dout;
   logic       cpu_doe;

   modport master (
      output cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_csel, cpu_mode, cpu_din,
      input  cpu_dout, cpu_doe
   );

   modport slave (
      input  cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_csel, cpu_mode, cpu_din,
      output cpu_dout, cpu_doe
   );
endinterface

// File: rtl/vdp_cpu_bus_ifce.sv
// CPU bus front end of the VDP: synchronizes and glitch-filters the CPU I/O strobes into
// single-clk read/write ticks for the VRAM data port (mode 0) and the register/status port (mode 1).
module vdp_cpu_bus_ifce #(
   parameter int unsigned FILTER = 2
) (
   input  logic               clk,
   input  logic               reset,
   vdp_cpu_bus_ifce_if.slave  bus,
   input  logic [7:0]         rdata0,
   input  logic [7:0]         rdata1,
   output logic               wr0_tick,
   output logic               rd0_tick,
   output logic               wr1_tick,
   output logic               rd1_tick,
   output logic [7:0]         wdata
);

   localparam logic [3:0] FILT = 4'(FILTER);

   typedef enum logic [1:0] {
      ST_HOLD,
      ST_IDLE,
      ST_QUAL
   } state_t;

   // Synchronizer flops carry no reset so they keep tracking the pins while reset is held;
   // that is what lets HOLD see a strobe that is still in flight at reset release.
   logic [12:0] meta_d, meta_q;
   logic [12:0] sync_d, sync_q;

   always_comb begin
      meta_d = {bus.cpu_iorq_n, bus.cpu_rd_n, bus.cpu_wr_n, bus.cpu_csel, bus.cpu_mode, bus.cpu_din};
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      meta_q <= meta_d;
      sync_q <= sync_d;
   end

   logic       iorq_n_s, rd_n_s, wr_n_s, csel_s, mode_s;
   logic [7:0] din_s;
   logic       act_rd, act_wr, act_same;

   assign {iorq_n_s, rd_n_s, wr_n_s, csel_s, mode_s, din_s} = sync_q;
   assign act_rd = !iorq_n_s && csel_s && !rd_n_s && wr_n_s;
   assign act_wr = !iorq_n_s && csel_s && !wr_n_s && rd_n_s;

   state_t     state_d, state_q;
   logic       kind_wr_d, kind_wr_q;
   logic       mode_d, mode_q;
   logic [3:0] cnt_d, cnt_q;
   logic       fire;

   logic       wr0_tick_d, wr0_tick_q;
   logic       rd0_tick_d, rd0_tick_q;
   logic       wr1_tick_d, wr1_tick_q;
   logic       rd1_tick_d, rd1_tick_q;
   logic [7:0] wdata_d, wdata_q;
   logic [7:0] dout_d, dout_q;
   logic       doe_d, doe_q;

   assign act_same = kind_wr_q ? act_wr : act_rd;

   // State register and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_HOLD;
         kind_wr_q  <= 1'b0;
         mode_q     <= 1'b0;
         cnt_q      <= 4'd0;
         wr0_tick_q <= 1'b0;
         rd0_tick_q <= 1'b0;
         wr1_tick_q <= 1'b0;
         rd1_tick_q <= 1'b0;
         wdata_q    <= 8'h00;
         dout_q     <= 8'h00;
         doe_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         kind_wr_q  <= kind_wr_d;
         mode_q     <= mode_d;
         cnt_q      <= cnt_d;
         wr0_tick_q <= wr0_tick_d;
         rd0_tick_q <= rd0_tick_d;
         wr1_tick_q <= wr1_tick_d;
         rd1_tick_q <= rd1_tick_d;
         wdata_q    <= wdata_d;
         dout_q     <= dout_d;
         doe_q      <= doe_d;
      end
   end

   // Next state: a strobe must stay the same kind and mode for FILTER synced samples to fire.
   always_comb begin
      state_d   = state_q;
      kind_wr_d = kind_wr_q;
      mode_d    = mode_q;
      cnt_d     = cnt_q;
      fire      = 1'b0;
      case (state_q)
         ST_HOLD: begin
            if (!act_rd && !act_wr) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (act_rd || act_wr) begin
               kind_wr_d = act_wr;
               mode_d    = mode_s;
               cnt_d     = 4'd1;
               if (FILT <= 4'd1) begin
                  fire    = 1'b1;
                  state_d = ST_HOLD;
               end else begin
                  state_d = ST_QUAL;
               end
            end
         end
         ST_QUAL: begin
            if (act_same && (mode_s == mode_q)) begin
               if ((cnt_q + 4'd1) >= FILT) begin
                  cnt_d   = FILT;
                  fire    = 1'b1;
                  state_d = ST_HOLD;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end else begin
               cnt_d   = 4'd0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_HOLD;
         end
      endcase
   end

   // Outputs: read data is captured on the tick edge so later rdata updates never reach the CPU bus.
   always_comb begin
      wr0_tick_d = 1'b0;
      rd0_tick_d = 1'b0;
      wr1_tick_d = 1'b0;
      rd1_tick_d = 1'b0;
      wdata_d    = wdata_q;
      dout_d     = dout_q;
      doe_d      = 1'b0;
      if (state_q == ST_HOLD) begin
         doe_d = doe_q && act_rd;
      end
      if (fire) begin
         if (kind_wr_d) begin
            wr0_tick_d = !mode_d;
            wr1_tick_d = mode_d;
            wdata_d    = din_s;
         end else begin
            rd0_tick_d = !mode_d;
            rd1_tick_d = mode_d;
            dout_d     = mode_d ? rdata1 : rdata0;
            doe_d      = 1'b1;
         end
      end
   end

   assign wr0_tick     = wr0_tick_q;
   assign rd0_tick     = rd0_tick_q;
   assign wr1_tick     = wr1_tick_q;
   assign rd1_tick     = rd1_tick_q;
   assign wdata        = wdata_q;
   assign bus.cpu_dout = dout_q;
   assign bus.cpu_doe  = doe_q;

endmodule

// File: tb/tb_vdp_cpu_bus_ifce.sv
// Directed bench for vdp_cpu_bus_ifce with FILTER=2: tick latency, glitch rejection,
// read-data hold, rd/wr conflict, back-to-back writes and reset during a strobe.
module tb_vdp_cpu_bus_ifce;

   logic       clk;
   logic       reset;
   logic [7:0] rdata0;
   logic [7:0] rdata1;
   logic       wr0_tick, rd0_tick, wr1_tick, rd1_tick;
   logic [7:0] wdata;

   int checks   = 0;
   int failures = 0;

   int wr0_seen    = 0;
   int rd0_seen    = 0;
   int wr1_seen    = 0;
   int rd1_seen    = 0;
   int doe_cycles  = 0;
   int multi_seen  = 0;

   vdp_cpu_bus_ifce_if bus ();

   vdp_cpu_bus_ifce #(.FILTER(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .rdata0   (rdata0),
      .rdata1   (rdata1),
      .wr0_tick (wr0_tick),
      .rd0_tick (rd0_tick),
      .wr1_tick (wr1_tick),
      .rd1_tick (rd1_tick),
      .wdata    (wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (wr0_tick) wr0_seen++;
      if (rd0_tick) rd0_seen++;
      if (wr1_tick) wr1_seen++;
      if (rd1_tick) rd1_seen++;
      if (bus.cpu_doe) doe_cycles++;
      if ((32'(wr0_tick) + 32'(rd0_tick) + 32'(wr1_tick) + 32'(rd1_tick)) > 1) multi_seen++;
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_stimulus(input logic iorq_n, input logic rd_n, input logic wr_n,
                                 input logic csel, input logic mode, input logic [7:0] din);
      bus.cpu_iorq_n = iorq_n;
      bus.cpu_rd_n   = rd_n;
      bus.cpu_wr_n   = wr_n;
      bus.cpu_csel   = csel;
      bus.cpu_mode   = mode;
      bus.cpu_din    = din;
   endtask

   task automatic bus_idle();
      apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      reset  = 1'b1;
      rdata0 = 8'h00;
      rdata1 = 8'h00;
      bus_idle();
      step(4);

      $display("[TB] reset state");
      check_output("rst_wr0_tick", 32'(wr0_tick), 32'd0);
      check_output("rst_rd0_tick", 32'(rd0_tick), 32'd0);
      check_output("rst_wr1_tick", 32'(wr1_tick), 32'd0);
      check_output("rst_rd1_tick", 32'(rd1_tick), 32'd0);
      check_output("rst_doe", 32'(bus.cpu_doe), 32'd0);
      check_output("rst_dout", 32'(bus.cpu_dout), 32'h00);
      check_output("rst_wdata", 32'(wdata), 32'h00);
      reset = 1'b0;
      step(3);

      $display("[TB] mode-1 write 0x8F held 6 clks");
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h8F);
      step(3);
      check_output("w8f_pre_tick", 32'(wr1_tick), 32'd0);
      check_output("w8f_pre_wdata", 32'(wdata), 32'h00);
      step(1);
      check_output("w8f_tick", 32'(wr1_tick), 32'd1);
      check_output("w8f_wdata", 32'(wdata), 32'h8F);
      check_output("w8f_doe", 32'(bus.cpu_doe), 32'd0);
      step(2);
      check_output("w8f_post_tick", 32'(wr1_tick), 32'd0);
      bus_idle();
      step(4);
      check_output("w8f_count", 32'(wr1_seen), 32'd1);
      check_output("w8f_wdata_held", 32'(wdata), 32'h8F);

      $display("[TB] mode-0 read glitch of one synced sample");
      rdata0 = 8'h3C;
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      step(1);
      bus_idle();
      step(6);
      check_output("glitch_rd0_count", 32'(rd0_seen), 32'd0);
      check_output("glitch_doe_cycles", 32'(doe_cycles), 32'd0);

      $display("[TB] mode-0 read of exactly FILTER synced samples");
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      step(2);
      bus_idle();
      step(2);
      check_output("edge_rd0_tick", 32'(rd0_tick), 32'd1);
      check_output("edge_dout", 32'(bus.cpu_dout), 32'h3C);
      step(1);
      check_output("edge_doe_drop", 32'(bus.cpu_doe), 32'd0);
      step(3);
      check_output("edge_doe_cycles", 32'(doe_cycles), 32'd1);

      $display("[TB] mode-1 read with status change after tick");
      rdata1 = 8'hA0;
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
      step(4);
      check_output("rd1_tick", 32'(rd1_tick), 32'd1);
      check_output("rd1_dout", 32'(bus.cpu_dout), 32'hA0);
      check_output("rd1_doe", 32'(bus.cpu_doe), 32'd1);
      rdata1 = 8'h00;
      step(3);
      check_output("rd1_hold_dout", 32'(bus.cpu_dout), 32'hA0);
      check_output("rd1_hold_doe", 32'(bus.cpu_doe), 32'd1);
      check_output("rd1_hold_tick", 32'(rd1_tick), 32'd0);
      bus_idle();
      step(2);
      check_output("rd1_release_doe_late", 32'(bus.cpu_doe), 32'd1);
      step(1);
      check_output("rd1_release_doe", 32'(bus.cpu_doe), 32'd0);
      check_output("rd1_release_dout", 32'(bus.cpu_dout), 32'hA0);
      check_output("rd1_doe_cycles", 32'(doe_cycles), 32'd7);
      check_output("rd1_count", 32'(rd1_seen), 32'd1);

      $display("[TB] rd_n and wr_n both low for 10 clks");
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77);
      step(10);
      bus_idle();
      step(4);
      check_output("conflict_ticks", 32'(wr0_seen + rd0_seen + wr1_seen + rd1_seen), 32'd3);
      check_output("conflict_doe_cycles", 32'(doe_cycles), 32'd7);
      check_output("conflict_wdata", 32'(wdata), 32'h8F);

      $display("[TB] back-to-back mode-1 writes 0x05 then 0x81");
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05);
      step(4);
      check_output("b2b_first_tick", 32'(wr1_tick), 32'd1);
      check_output("b2b_first_wdata", 32'(wdata), 32'h05);
      bus_idle();
      step(2);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h81);
      step(3);
      check_output("b2b_second_pre", 32'(wr1_tick), 32'd0);
      check_output("b2b_wdata_between", 32'(wdata), 32'h05);
      step(1);
      check_output("b2b_second_tick", 32'(wr1_tick), 32'd1);
      check_output("b2b_second_wdata", 32'(wdata), 32'h81);
      bus_idle();
      step(4);
      check_output("b2b_count", 32'(wr1_seen), 32'd3);

      $display("[TB] mode-0 write 0x42");
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h42);
      step(4);
      check_output("w0_tick", 32'(wr0_tick), 32'd1);
      check_output("w0_wr1_quiet", 32'(wr1_tick), 32'd0);
      check_output("w0_wdata", 32'(wdata), 32'h42);
      bus_idle();
      step(4);
      check_output("w0_count", 32'(wr0_seen), 32'd1);

      $display("[TB] reset during a mode-0 read");
      rdata0 = 8'h55;
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      step(5);
      check_output("rstrd_doe_before", 32'(bus.cpu_doe), 32'd1);
      check_output("rstrd_dout_before", 32'(bus.cpu_dout), 32'h55);
      reset = 1'b1;
      step(1);
      check_output("rstrd_doe_drop", 32'(bus.cpu_doe), 32'd0);
      check_output("rstrd_dout_clear", 32'(bus.cpu_dout), 32'h00);
      step(2);
      reset = 1'b0;
      step(8);
      check_output("rstrd_no_retick", 32'(rd0_seen), 32'd2);
      check_output("rstrd_doe_quiet", 32'(bus.cpu_doe), 32'd0);
      bus_idle();
      step(4);
      rdata0 = 8'h66;
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      step(4);
      check_output("rstrd_next_tick", 32'(rd0_tick), 32'd1);
      check_output("rstrd_next_dout", 32'(bus.cpu_dout), 32'h66);
      check_output("rstrd_next_doe", 32'(bus.cpu_doe), 32'd1);
      bus_idle();
      step(4);
      check_output("rstrd_final_doe", 32'(bus.cpu_doe), 32'd0);
      check_output("rstrd_rd0_count", 32'(rd0_seen), 32'd3);

      check_output("multi_tick_cycles", 32'(multi_seen), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
